// File: rtl/sound_mixer_pwm.sv
// Stereo audio back end: timer-pulse moving average, weighted channel mix with
// saturation, 1-bit PWM or sigma-delta DAC per side, hysteretic tape input bit.
module sound_mixer_pwm #(
  parameter int unsigned N_CH        = 7,
  parameter int unsigned N_PULSE     = 4,
  parameter int unsigned MA_LOG2     = 2,
  parameter int unsigned DECIM_LOG2  = 9,
  parameter int unsigned PULSE_SHIFT = 9,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned PWM_WIDTH   = 10,
  parameter int unsigned MODE        = 0,
  parameter int unsigned HYST        = 4
) (
  input  logic                   clk24,
  input  logic                   reset,
  input  logic [N_PULSE-1:0]     pulses,
  input  logic [8*N_CH-1:0]      ch_data,
  input  logic [3*N_CH-1:0]      gain_l,
  input  logic [3*N_CH-1:0]      gain_r,
  input  logic                   clip_clr,
  input  logic [7:0]             tape_adc,
  input  logic                   tape_adc_valid,
  output logic [OUT_WIDTH-1:0]   pcm_l,
  output logic [OUT_WIDTH-1:0]   pcm_r,
  output logic                   pcm_strobe,
  output logic                   dac_l,
  output logic                   dac_r,
  output logic                   clip_l,
  output logic                   clip_r,
  output logic                   tapein
);

  localparam int unsigned PC_W     = $clog2(N_PULSE + 1);
  localparam int unsigned MA_DEPTH = 1 << MA_LOG2;
  localparam int unsigned PTR_W    = (MA_LOG2 > 0) ? MA_LOG2 : 1;
  localparam int unsigned SUM_W    = $clog2(N_PULSE * MA_DEPTH + 1);
  localparam int unsigned ACC_W    = OUT_WIDTH + 4;

  localparam logic [7:0] TAPE_HI = 8'(128 + HYST);
  localparam logic [7:0] TAPE_LO = 8'(128 - HYST);

  logic [DECIM_LOG2-1:0] dcnt;
  logic                  ce_c;
  logic                  mix_en;
  logic [PC_W-1:0]       pcount_c;
  logic [PC_W-1:0]       hist [MA_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PC_W-1:0]       oldest_c;
  logic [SUM_W-1:0]      ma_sum;
  logic [ACC_W-1:0]      pulse_term_c;
  logic [ACC_W-1:0]      sum_l_c;
  logic [ACC_W-1:0]      sum_r_c;
  logic                  ovf_l_c;
  logic                  ovf_r_c;
  logic [OUT_WIDTH-1:0]  sat_l_c;
  logic [OUT_WIDTH-1:0]  sat_r_c;

  // Weighted channel contribution: code 0 mutes, otherwise a left shift by code-1.
  function automatic logic [ACC_W-1:0] ch_term(input logic [7:0] ch, input logic [2:0] g);
    logic [ACC_W-1:0] t;
    t = '0;
    if (g != 3'd0) t = ACC_W'(ch) << (g - 3'd1);
    return t;
  endfunction

  // Free-running sample-period counter.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) dcnt <= '0;
    else       dcnt <= dcnt + DECIM_LOG2'(1);
  end

  assign ce_c = (dcnt == '0);

  // Number of timer pulses high at this instant.
  always_comb begin
    pcount_c = '0;
    for (int unsigned i = 0; i < N_PULSE; i++) pcount_c = pcount_c + PC_W'(pulses[i]);
  end

  assign oldest_c = hist[wptr];

  // Moving-average history ring and running sum; mix enable trails ce by one cycle.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < MA_DEPTH; i++) hist[i] <= '0;
      wptr   <= '0;
      ma_sum <= '0;
      mix_en <= 1'b0;
    end else begin
      mix_en <= ce_c;
      if (ce_c) begin
        hist[wptr] <= pcount_c;
        wptr       <= (wptr == PTR_W'(MA_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
        ma_sum     <= ma_sum + SUM_W'(pcount_c) - SUM_W'(oldest_c);
      end
    end
  end

  assign pulse_term_c = ACC_W'(ma_sum >> MA_LOG2) << PULSE_SHIFT;

  // Stereo mix sum with wide headroom, then saturation to the PCM width.
  always_comb begin
    sum_l_c = pulse_term_c;
    sum_r_c = pulse_term_c;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sum_l_c = sum_l_c + ch_term(ch_data[8*i +: 8], gain_l[3*i +: 3]);
      sum_r_c = sum_r_c + ch_term(ch_data[8*i +: 8], gain_r[3*i +: 3]);
    end
    ovf_l_c = |sum_l_c[ACC_W-1:OUT_WIDTH];
    ovf_r_c = |sum_r_c[ACC_W-1:OUT_WIDTH];
    sat_l_c = ovf_l_c ? '1 : sum_l_c[OUT_WIDTH-1:0];
    sat_r_c = ovf_r_c ? '1 : sum_r_c[OUT_WIDTH-1:0];
  end

  // PCM output registers and their one-cycle strobe.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      pcm_l      <= '0;
      pcm_r      <= '0;
      pcm_strobe <= 1'b0;
    end else begin
      pcm_strobe <= mix_en;
      if (mix_en) begin
        pcm_l <= sat_l_c;
        pcm_r <= sat_r_c;
      end
    end
  end

  // Sticky clip flags; a new clip outranks a simultaneous clear.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      clip_l <= 1'b0;
      clip_r <= 1'b0;
    end else begin
      if (mix_en && ovf_l_c) clip_l <= 1'b1;
      else if (clip_clr)     clip_l <= 1'b0;
      if (mix_en && ovf_r_c) clip_r <= 1'b1;
      else if (clip_clr)     clip_r <= 1'b0;
    end
  end

  if (MODE == 0) begin : g_pwm
    logic [PWM_WIDTH-1:0] cnt;

    // PWM: free-running ramp compared against the top PCM bits.
    always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        dac_l <= 1'b0;
        dac_r <= 1'b0;
      end else begin
        cnt   <= cnt + PWM_WIDTH'(1);
        dac_l <= (cnt < pcm_l[OUT_WIDTH-1 -: PWM_WIDTH]);
        dac_r <= (cnt < pcm_r[OUT_WIDTH-1 -: PWM_WIDTH]);
      end
    end
  end else begin : g_sd
    logic [OUT_WIDTH:0] acc_l;
    logic [OUT_WIDTH:0] acc_r;

    // First-order sigma-delta: the accumulator carry is the bitstream.
    always_ff @(posedge clk24 or posedge reset) begin
      if (reset) begin
        acc_l <= '0;
        acc_r <= '0;
      end else begin
        acc_l <= {1'b0, acc_l[OUT_WIDTH-1:0]} + {1'b0, pcm_l};
        acc_r <= {1'b0, acc_r[OUT_WIDTH-1:0]} + {1'b0, pcm_r};
      end
    end

    assign dac_l = acc_l[OUT_WIDTH];
    assign dac_r = acc_r[OUT_WIDTH];
  end

  // Tape comparator with hysteresis band around the ADC midpoint.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      tapein <= 1'b0;
    end else if (tape_adc_valid) begin
      if (tape_adc > TAPE_HI)      tapein <= 1'b1;
      else if (tape_adc < TAPE_LO) tapein <= 1'b0;
    end
  end

endmodule
